// File: rtl/inst_mem_boot.sv
// inst_mem_boot: writable instruction memory with a 1-cycle registered read port and a byte-stream boot loader
//   Parameters: DEPTH_LOG2 (log2 word count), NOP_WORD (value read while busy or out of range)
//   Ports: clk, rst_n (async active-low); ReadAddr/ReadEn -> ReadInst (holds when ReadEn=0);
//          BootStart/BootData/BootValid -> BootReady; status Busy, Overflow (sticky), WordsLoaded;
//          ChecksumOk exists only when INST_MEM_CHECKSUM_EN is defined.
module inst_mem_boot #(
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         ReadAddr,
  input  logic                ReadEn,
  output logic [31:0]         ReadInst,
  input  logic                BootStart,
  input  logic [7:0]          BootData,
  input  logic                BootValid,
  output logic                BootReady,
  output logic                Busy,
  output logic                Overflow,
  output logic [DEPTH_LOG2:0] WordsLoaded
`ifdef INST_MEM_CHECKSUM_EN
  ,
  output logic                ChecksumOk
`endif
);
  localparam logic [16:0] DEPTH = 17'(1) << DEPTH_LOG2;
  typedef enum logic [2:0] {
    RUN, LEN0, LEN1, DATA,
`ifdef INST_MEM_CHECKSUM_EN
    CSUM,
`endif
    DONE
  } state_e;
  state_e              state_q;
  logic [31:0]         mem [0:(1<<DEPTH_LOG2)-1];
  logic [31:0]         read_q, shift_q, word_d;
  logic [15:0]         n_q;
  logic [16:0]         widx_q, widx_d;
  logic [1:0]          cnt_q;
  logic                ovf_q, acc, shifting, last_byte, in_range, we, rd_oor, unused_addr;
  logic [DEPTH_LOG2:0] wl_q;
`ifdef INST_MEM_CHECKSUM_EN
  logic [31:0]         sum_q;
  logic                ok_q;
  assign shifting   = state_q == DATA || state_q == CSUM;
  assign ChecksumOk = ok_q;
`else
  assign shifting   = state_q == DATA;
`endif
  assign BootReady   = state_q != RUN && state_q != DONE;
  assign Busy        = BootReady;
  assign acc         = BootValid && BootReady;
  // little-endian assembly: the newest byte enters at the top, so byte 0 ends in [7:0]
  assign word_d      = {BootData, shift_q[31:8]};
  assign last_byte   = acc && shifting && cnt_q == 2'd3;
  assign widx_d      = widx_q + 17'd1;
  assign in_range    = widx_q < DEPTH;
  assign we          = last_byte && state_q == DATA && in_range;
  assign rd_oor      = (ReadAddr[31:2] >> DEPTH_LOG2) != 30'd0;
  assign unused_addr = ^ReadAddr[1:0];
  assign ReadInst    = read_q;
  assign Overflow    = ovf_q;
  assign WordsLoaded = wl_q;
  always_ff @(posedge clk) if (we) mem[widx_q[DEPTH_LOG2-1:0]] <= word_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_q  <= NOP_WORD;
      state_q <= RUN;
      shift_q <= '0;
      n_q     <= '0;
      widx_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      wl_q    <= '0;
`ifdef INST_MEM_CHECKSUM_EN
      sum_q   <= '0;
      ok_q    <= 1'b0;
`endif
    end else begin
      if (ReadEn) read_q <= (rd_oor || Busy) ? NOP_WORD : mem[ReadAddr[DEPTH_LOG2+1:2]];
      if (acc && shifting) begin
        shift_q <= word_d;
        cnt_q   <= cnt_q + 2'd1;
      end
      case (state_q)
        RUN: if (BootStart) begin
          state_q <= LEN0;
          ovf_q   <= 1'b0;
          wl_q    <= '0;
          widx_q  <= '0;
          cnt_q   <= '0;
`ifdef INST_MEM_CHECKSUM_EN
          sum_q   <= '0;
          ok_q    <= 1'b0;
`endif
        end
        LEN0: if (acc) begin
          n_q[7:0] <= BootData;
          state_q  <= LEN1;
        end
        LEN1: if (acc) begin
          n_q[15:8] <= BootData;
          ovf_q     <= {1'b0, BootData, n_q[7:0]} > DEPTH;
          state_q   <= {BootData, n_q[7:0]} == 16'd0 ? DONE : DATA;
        end
        DATA: if (last_byte) begin
          widx_q <= widx_d;
          if (in_range) wl_q <= widx_d[DEPTH_LOG2:0];
`ifdef INST_MEM_CHECKSUM_EN
          sum_q <= sum_q + word_d;
          if (widx_d == {1'b0, n_q}) state_q <= CSUM;
`else
          if (widx_d == {1'b0, n_q}) state_q <= DONE;
`endif
        end
`ifdef INST_MEM_CHECKSUM_EN
        CSUM: if (last_byte) begin
          ok_q    <= sum_q == word_d;
          state_q <= DONE;
        end
`endif
        default: state_q <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_mem_boot.sv
// tb_inst_mem_boot: randomized scoreboard bench for inst_mem_boot against a word-array reference model
module tb_inst_mem_boot;
  localparam logic [31:0] NOP = 32'h0000_0000;
  logic        clk = 1'b0, rst_n = 1'b0, ReadEn = 1'b0, BootStart = 1'b0, BootValid = 1'b0;
  logic [31:0] ReadAddr = '0;
  logic [7:0]  BootData = '0;
  logic [31:0] ReadInst;
  logic        BootReady, Busy, Overflow;
  logic [8:0]  WordsLoaded;
`ifdef INST_MEM_CHECKSUM_EN
  logic        ChecksumOk;
`endif
  int          tests = 0, fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_m [256];

  inst_mem_boot dut (
    .clk(clk), .rst_n(rst_n), .ReadAddr(ReadAddr), .ReadEn(ReadEn), .ReadInst(ReadInst),
    .BootStart(BootStart), .BootData(BootData), .BootValid(BootValid), .BootReady(BootReady),
    .Busy(Busy), .Overflow(Overflow), .WordsLoaded(WordsLoaded)
`ifdef INST_MEM_CHECKSUM_EN
    , .ChecksumOk(ChecksumOk)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: a read captured on a rising edge is checked at the following falling edge
  initial begin : monitor
    logic fire;
    forever begin
      @(posedge clk);
      fire = ReadEn && rst_n;
      @(negedge clk);
      if (fire) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL read_unexpected: got %0h with no expectation queued", ReadInst);
        end else chk("read", ReadInst, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] addr, input bit busy);
    logic [29:0] i;
    i = addr[31:2];
    ReadEn = 1'b1;
    ReadAddr = addr;
    exp_q.push_back((busy || i >= 30'd256) ? NOP : mem_m[i[7:0]]);
    tick();
    ReadEn = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    int w;
    w = 0;
    if (gap) repeat ($urandom_range(0, 2)) tick();
    BootValid = 1'b1;
    BootData = b;
    while (!BootReady && w < 20) begin
      tick();
      w++;
    end
    if (!BootReady) begin
      tests++;
      fails++;
      $display("FAIL boot_ready_timeout: BootReady=%0b required 1", BootReady);
    end
    tick();
    BootValid = 1'b0;
  endtask

  task automatic boot(input logic [31:0] words[$], input int n, input bit gap, input bit bad_csum);
    logic [31:0] s, w, c;
    s = '0;
    BootStart = 1'b1;
    tick();
    BootStart = 1'b0;
    chk("busy_start", Busy, 1);
    chk("ready_start", BootReady, 1);
    rd(32'd0, 1'b1);
    send(n[7:0], gap);
    send(n[15:8], gap);
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      for (int k = 0; k < 4; k++) send(w[8*k +: 8], gap);
      s += w;
      if (i < 256) mem_m[i] = w;
    end
`ifdef INST_MEM_CHECKSUM_EN
    c = bad_csum ? s ^ 32'h0000_0001 : s;
    if (n != 0) for (int k = 0; k < 4; k++) send(c[8*k +: 8], gap);
    chk("checksum_ok", ChecksumOk, (n != 0) && !bad_csum);
`else
    c = s;
`endif
    chk("busy_done", Busy, 0);
    chk("words_loaded", WordsLoaded, (n > 256) ? 256 : n);
    chk("overflow", Overflow, n > 256);
    tick();
  endtask

  initial begin
    logic [31:0] basic[$], rnd[$], w0;
    int          wait_n;
    basic.push_back(32'h2008_0002);
    basic.push_back(32'h2009_0001);
    ReadEn = 1'b1;
    repeat (2) tick();
    chk("reset_readinst", ReadInst, NOP);
    chk("reset_busy", Busy, 0);
    chk("reset_ready", BootReady, 0);
    chk("reset_overflow", Overflow, 0);
    chk("reset_words", WordsLoaded, 0);
    ReadEn = 1'b0;
    rst_n = 1'b1;
    tick();
    BootValid = 1'b1;
    BootData = 8'hAA;
    repeat (3) tick();
    chk("run_ready", BootReady, 0);
    chk("run_busy", Busy, 0);
    BootValid = 1'b0;
    tick();
    boot(basic, 2, 1'b0, 1'b0);
    rd(32'd0, 1'b0);
    rd(32'd4, 1'b0);
    rd(32'd0, 1'b0);
    ReadAddr = 32'd4;
    repeat (3) begin
      tick();
      chk("stall_hold", ReadInst, mem_m[0]);
    end
    rd(32'd4, 1'b0);
    rd(32'd7, 1'b0);
    rd(32'd1024, 1'b0);
    rd(32'hFFFF_FFFC, 1'b0);
    boot(rnd, 0, 1'b0, 1'b0);
    rd(32'd0, 1'b0);
    rd(32'd4, 1'b0);
    for (int i = 0; i < 6; i++) rnd.push_back($urandom);
    boot(rnd, 6, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) rd(32'(4 * i) | 32'($urandom_range(0, 3)), 1'b0);
    boot(basic, 2, 1'b1, 1'b0);
    rd(32'd0, 1'b0);
    rd(32'd4, 1'b0);
    rd(32'd8, 1'b0);
    rnd = {};
    for (int i = 0; i < 257; i++) rnd.push_back($urandom);
    boot(rnd, 257, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) rd(32'(4 * $urandom_range(0, 255)), 1'b0);
    rd(32'd1020, 1'b0);
    rd(32'd1024, 1'b0);
    w0 = $urandom;
    BootStart = 1'b1;
    tick();
    BootStart = 1'b0;
    send(8'd2, 1'b0);
    send(8'd0, 1'b0);
    for (int k = 0; k < 4; k++) send(w0[8*k +: 8], 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    mem_m[0] = w0;
    chk("midload_busy", Busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", Busy, 0);
    chk("midreset_ready", BootReady, 0);
    chk("midreset_words", WordsLoaded, 0);
    chk("midreset_readinst", ReadInst, NOP);
    tick();
    tick();
    rst_n = 1'b1;
    rd(32'd0, 1'b0);
    rd(32'd4, 1'b0);
    wait_n = 0;
    while (exp_q.size() != 0 && wait_n < 10) begin
      tick();
      wait_n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d reads outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
